coo_dec_hls_deadlock_monitor_gen: RTL and testbench

Parametrised deadlock monitor for one HLS dataflow region of the coo_dec accelerator, generalising the fixed per-instance monitor. It merges AXIS-blocking flags from the region's own streams, from single sub-instance streams and from child monitors, plus an all-instances-stuck condition. It debounces them over a programmable persistence window and reports block, sticky, first-source and optional duration information to the top-level debug logic.

---
 rtl/coo_dec_hls_deadlock_monitor_gen.sv | 129 ++++++++++++
 tb/tb_coo_dec_hls_deadlock_monitor_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coo_dec_hls_deadlock_monitor_gen.sv
// Deadlock monitor for one HLS dataflow region: merges stream, child and instance-stuck sources
// and debounces them over THRESH cycles. Define DEADLOCK_MON_DURATION_EN to build stall_cycles.
module coo_dec_hls_deadlock_monitor_gen #(
    parameter int unsigned         NUM_AXIS   = 4,
    parameter logic [NUM_AXIS-1:0] SUB_MASK   = 4'b1100,
    parameter int unsigned         NUM_CHILD  = 1,
    parameter int unsigned         NUM_INST   = 3,
    parameter int unsigned         THRESH     = 1,
    parameter bit                  INST_CHECK = 1'b1,
    localparam int unsigned        NUM_SRC    = NUM_AXIS + NUM_CHILD + 1,
    localparam int unsigned        SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_AXIS-1:0]  axis_block_sigs,
    input  logic [NUM_CHILD-1:0] child_block_sigs,
    input  logic [NUM_INST-1:0]  inst_idle_sigs,
    input  logic [NUM_INST-1:0]  inst_block_sigs,
    input  logic                 clear_sticky,
    output logic                 block,
    output logic                 block_sticky,
    output logic [SRC_W-1:0]     first_src,
    output logic [15:0]          stall_cycles
);

    localparam int unsigned CNT_W = $clog2(THRESH + 1);

    typedef enum logic [1:0] {StIdle, StSuspect, StBlocked} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W:0]     cnt_inc;
    logic               cur_axis;
    logic               sub_axis;
    logic               child;
    logic               inst_term;
    logic               raw;
    logic               enter;
    logic [NUM_SRC-1:0] src;
    logic [SRC_W-1:0]   low_idx;

    assign cur_axis  = |(axis_block_sigs & ~SUB_MASK);
    assign sub_axis  = |(axis_block_sigs & SUB_MASK);
    assign child     = |child_block_sigs;
    // Every instance idle or blocked, with at least one actually blocked.
    assign inst_term = INST_CHECK && (&(inst_idle_sigs | inst_block_sigs)) && (|inst_block_sigs);
    assign raw       = cur_axis | sub_axis | child | inst_term;
    assign src       = {inst_term, child_block_sigs, axis_block_sigs};
    assign cnt_inc   = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    assign enter = raw && ((state_q == StIdle && THRESH == 1) ||
                           (state_q == StSuspect && cnt_inc == (CNT_W + 1)'(THRESH)));

    always_comb begin
        low_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src[i]) low_idx = SRC_W'(i);
        end
    end

    assign block = (state_q == StBlocked);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            block_sticky <= 1'b0;
            first_src    <= '0;
        end else begin
            // A block entry outranks a simultaneous clear.
            if (enter) begin
                first_src    <= low_idx;
                block_sticky <= 1'b1;
            end else if (clear_sticky) begin
                block_sticky <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (raw) begin
                        if (THRESH == 1) begin
                            state_q <= StBlocked;
                        end else begin
                            state_q <= StSuspect;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                StSuspect: begin
                    if (!raw) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc[CNT_W-1:0];
                        if (enter) state_q <= StBlocked;
                    end
                end
                StBlocked: begin
                    if (!raw) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef DEADLOCK_MON_DURATION_EN
    logic [15:0] stall_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_q <= 16'h0000;
        end else if (enter) begin
            stall_q <= 16'h0001;
        end else if (state_q == StBlocked && raw && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_coo_dec_hls_deadlock_monitor_gen.sv
// Self-checking bench for coo_dec_hls_deadlock_monitor_gen: four parameterisations share stimulus,
// expectations are queued per cycle and compared against the instance they describe.
module tb_coo_dec_hls_deadlock_monitor_gen;

`ifdef DEADLOCK_MON_DURATION_EN
    localparam bit DUR = 1'b1;
`else
    localparam bit DUR = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] axis_block_sigs;
    logic [0:0] child_block_sigs;
    logic [2:0] inst_idle_sigs;
    logic [2:0] inst_block_sigs;
    logic       clear_sticky;

    logic        a_block, b_block, c_block, d_block;
    logic        a_sticky, b_sticky, c_sticky, d_sticky;
    logic [2:0]  a_first, b_first, c_first, d_first;
    logic [15:0] a_stall, b_stall, c_stall, d_stall;

    typedef struct {
        int          dut;
        string       name;
        logic [20:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    // dut 0: defaults, dut 1: THRESH=4, dut 2: INST_CHECK=0, dut 3: THRESH=2
    coo_dec_hls_deadlock_monitor_gen dut_a (
        .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
        .child_block_sigs(child_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs), .clear_sticky(clear_sticky),
        .block(a_block), .block_sticky(a_sticky), .first_src(a_first), .stall_cycles(a_stall)
    );

    coo_dec_hls_deadlock_monitor_gen #(.THRESH(4)) dut_b (
        .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
        .child_block_sigs(child_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs), .clear_sticky(clear_sticky),
        .block(b_block), .block_sticky(b_sticky), .first_src(b_first), .stall_cycles(b_stall)
    );

    coo_dec_hls_deadlock_monitor_gen #(.INST_CHECK(1'b0)) dut_c (
        .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
        .child_block_sigs(child_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs), .clear_sticky(clear_sticky),
        .block(c_block), .block_sticky(c_sticky), .first_src(c_first), .stall_cycles(c_stall)
    );

    coo_dec_hls_deadlock_monitor_gen #(.THRESH(2)) dut_d (
        .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
        .child_block_sigs(child_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs), .clear_sticky(clear_sticky),
        .block(d_block), .block_sticky(d_sticky), .first_src(d_first), .stall_cycles(d_stall)
    );

    function automatic logic [20:0] obs_of(input int d);
        case (d)
            0:       return {a_block, a_sticky, a_first, a_stall};
            1:       return {b_block, b_sticky, b_first, b_stall};
            2:       return {c_block, c_sticky, c_first, c_stall};
            default: return {d_block, d_sticky, d_first, d_stall};
        endcase
    endfunction

    task automatic push(input int d, input string nm, input bit blk, input bit stk,
                        input int fs, input int st);
        logic [15:0] s;
        s = DUR ? 16'(st) : 16'h0000;
        sb.push_back('{d, nm, {blk, stk, 3'(fs), s}});
    endtask

    task automatic tick(input logic [3:0] ax, input logic ch, input logic [2:0] id,
                        input logic [2:0] ib, input logic clr);
        axis_block_sigs  = ax;
        child_block_sigs = ch;
        inst_idle_sigs   = id;
        inst_block_sigs  = ib;
        clear_sticky     = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset_n = 1'b0;
        for (int d = 0; d < 4; d++) push(d, "reset", 0, 0, 0, 0);
        tick(4'b0000, 1'b0, 3'b000, 3'b000, 1'b0);
        reset_n = 1'b1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (obs_of(e.dut) !== e.v) begin
                failures++;
                $display("FAIL %s dut%0d: got %h required %h", e.name, e.dut, obs_of(e.dut), e.v);
            end
        end
    endtask

    task automatic test_thresh1();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            push(0, "thresh1", i == 0, i < 3, 0, 1);
            tick((i == 0) ? 4'b0001 : 4'b0000, 1'b0, 3'b000, 3'b000, i == 3);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (obs_of(e.dut) !== e.v) begin
                    failures++;
                    $display("FAIL %s dut%0d step%0d: got %h required %h",
                             e.name, e.dut, i, obs_of(e.dut), e.v);
                end
            end
        end
    endtask

    task automatic test_inst_stuck();
        exp_t e;
        logic [2:0] id, ib;
        for (int i = 0; i < 4; i++) begin
            id = (i == 0) ? 3'b101 : (i == 2) ? 3'b100 : 3'b000;
            ib = (i == 0 || i == 2) ? 3'b010 : 3'b000;
            push(0, "inst_stuck", i == 0, i < 3, 5, 1);
            if (i == 0) push(2, "inst_check_off", 0, 0, 0, 1);
            tick(4'b0000, 1'b0, id, ib, i == 3);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (obs_of(e.dut) !== e.v) begin
                    failures++;
                    $display("FAIL %s dut%0d step%0d: got %h required %h",
                             e.name, e.dut, i, obs_of(e.dut), e.v);
                end
            end
        end
    endtask

    task automatic test_priority_clear();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            push(0, "priority_clear", i < 2, i < 2, 3, i + 1 - (i / 2));
            tick((i < 2) ? 4'b1000 : 4'b0000, i < 2, 3'b000, 3'b000, i != 1);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (obs_of(e.dut) !== e.v) begin
                    failures++;
                    $display("FAIL %s dut%0d step%0d: got %h required %h",
                             e.name, e.dut, i, obs_of(e.dut), e.v);
                end
            end
        end
    endtask

    task automatic test_thresh4();
        exp_t e;
        logic hi;
        for (int i = 0; i < 11; i++) begin
            hi = (i < 3) || (i >= 4 && i < 9);
            push(1, "thresh4", i == 7 || i == 8, i >= 7, (i >= 7) ? 2 : 0,
                 (i == 7) ? 1 : (i > 7) ? 2 : 0);
            tick(hi ? 4'b0100 : 4'b0000, 1'b0, 3'b000, 3'b000, 1'b0);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (obs_of(e.dut) !== e.v) begin
                    failures++;
                    $display("FAIL %s dut%0d step%0d: got %h required %h",
                             e.name, e.dut, i, obs_of(e.dut), e.v);
                end
            end
        end
    endtask

    task automatic test_reset_mid_episode();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            reset_n = (i != 1);
            if (i == 0) begin
                push(0, "rst_mid_pre", 1, 1, 0, 1);
                push(1, "rst_mid_pre", 0, 1, 2, 2);
            end else if (i == 1) begin
                push(0, "rst_mid", 0, 0, 0, 0);
                push(1, "rst_mid", 0, 0, 0, 0);
            end else if (i < 6) begin
                push(0, "rst_rearm", 1, 1, 0, i - 1);
                push(1, "rst_rearm", i == 5, i == 5, 0, (i == 5) ? 1 : 0);
            end else begin
                push(0, "rst_drop", 0, 1, 0, 4);
                push(1, "rst_drop", 0, 1, 0, 1);
            end
            tick((i < 6) ? 4'b0001 : 4'b0000, 1'b0, 3'b000, 3'b000, 1'b0);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (obs_of(e.dut) !== e.v) begin
                    failures++;
                    $display("FAIL %s dut%0d step%0d: got %h required %h",
                             e.name, e.dut, i, obs_of(e.dut), e.v);
                end
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_duration();
        exp_t e;
        for (int i = 0; i < 13; i++) begin
            reset_n = (i != 0);
            if (i == 0)       push(3, "duration_rst", 0, 0, 0, 0);
            else if (i <= 10) push(3, "duration", i >= 2, i >= 2, 0, (i >= 2) ? i - 1 : 0);
            else              push(3, "duration_hold", 0, 1, 0, 9);
            tick((i >= 1 && i <= 10) ? 4'b0001 : 4'b0000, 1'b0, 3'b000, 3'b000, 1'b0);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (obs_of(e.dut) !== e.v) begin
                    failures++;
                    $display("FAIL %s dut%0d step%0d: got %h required %h",
                             e.name, e.dut, i, obs_of(e.dut), e.v);
                end
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n          = 1'b0;
        axis_block_sigs  = '0;
        child_block_sigs = '0;
        inst_idle_sigs   = '0;
        inst_block_sigs  = '0;
        clear_sticky     = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_thresh1();
        test_inst_stuck();
        test_priority_clear();
        test_thresh4();
        test_reset_mid_episode();
        test_duration();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
